// File: rtl/uart16550_pkg.sv
// Shared types for the 16550 receive path: FSM states, LCR/CSR view,
// received-character record and the frame-length helper.
package uart16550_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxp_state_t;

   typedef struct packed {
      logic       dlab;
      logic       set_break;
      logic       stick_parity;
      logic       eps;
      logic       pen;
      logic       stb;
      logic [1:0] wls;
   } lcr_t;

   typedef struct packed {
      lcr_t lcr;
   } csr_t;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       bi;
   } rxp_d_t;

   // Oversample ticks in one complete character, stop bits included.
   function automatic int unsigned rxp_frame_ticks(input lcr_t lcr, input int unsigned os);
      int unsigned f;
      f = os * (32'd7 + 32'(lcr.wls) + 32'(lcr.pen));
      if (lcr.stb) f = f + ((lcr.wls == 2'd0) ? os / 2 : os);
      return f;
   endfunction

endpackage

// File: rtl/uart16550_rx_sampler.sv
// sin synchroniser plus tick-rate history: falling-edge detect and
// 3-sample majority over the current and two previous baud ticks.
module uart16550_rx_sampler #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic sin_i,
   output logic sin_s_o,
   output logic fall_o,
   output logic maj_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]             hist_q, hist_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sin_i};
      hist_d = hist_q;
      if (tick_i) hist_d = {hist_q[0], s};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '1;
         hist_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   // Edge is judged against the previous tick's sample, so it lands on a tick cycle.
   assign sin_s_o = s;
   assign fall_o  = tick_i & hist_q[0] & ~s;
   assign maj_o   = (hist_q[1] & hist_q[0]) | (hist_q[1] & s) | (hist_q[0] & s);

endmodule

// File: rtl/uart16550_rxp.sv
// 16550 receive path: frame FSM, break detection and RxFIFO push.
// Optional character timeout is built when UART16550_RXP_TIMEOUT_EN is defined.
module uart16550_rxp
   import uart16550_pkg::*;
#(
   parameter int unsigned OVERSAMPLE    = 16,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned TIMEOUT_CHARS = 4
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   baudout_i,
   input  csr_t   csr_i,
   input  logic   sin_i,
   input  logic   fifo_empty_i,
   input  logic   fifo_rd_i,
   output logic   push_o,
   output rxp_d_t q_o,
   output logic   break_o,
   output logic   timeout_o
);

   localparam int unsigned      MID       = OVERSAMPLE / 2;
   localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CHARS * OVERSAMPLE * 12 + 1);
   localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(MID + 1);
   localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(OVERSAMPLE - 1);

   logic sin_s, fall, maj;

   uart16550_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .tick_i  (baudout_i),
      .sin_i   (sin_i),
      .sin_s_o (sin_s),
      .fall_o  (fall),
      .maj_o   (maj)
   );

   rxp_state_t       state_q, state_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d, bit_cnt_q, bit_cnt_d, brk_cnt_q, brk_cnt_d;
   logic [7:0]       data_q, data_d;
   logic             pe_q, pe_d, all_low_q, all_low_d, pend_q, pend_d;
   logic             break_q, break_d, push_q, push_d;
   rxp_d_t           q_q, q_d;
   logic [CNT_W-1:0] frame_ticks, last_bit;
   logic             sample_tick, bit_end, exp_par, brk_hit;
   logic             unused_csr;

   assign frame_ticks = CNT_W'(rxp_frame_ticks(csr_i.lcr, OVERSAMPLE));
   assign last_bit    = CNT_W'(4) + CNT_W'(csr_i.lcr.wls);
   assign sample_tick = baudout_i && (tick_cnt_q == SAMPLE_AT);
   assign bit_end     = baudout_i && (tick_cnt_q == BIT_END);
   assign exp_par     = csr_i.lcr.stick_parity ? ~csr_i.lcr.eps
                                               : (csr_i.lcr.eps ? ^data_q : ~^data_q);
   assign brk_hit     = baudout_i && !sin_s && (brk_cnt_q == CNT_W'(1));
   assign unused_csr  = ^{csr_i.lcr.dlab, csr_i.lcr.set_break};

   // An all-low frame ending in a framing error is held back: it either becomes
   // the break character or is pushed as a plain framing error once sin rises.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      brk_cnt_d  = brk_cnt_q;
      data_d     = data_q;
      pe_d       = pe_q;
      all_low_d  = all_low_q && !sin_s;
      pend_d     = pend_q;
      break_d    = break_q && !sin_s;
      push_d     = 1'b0;
      q_d        = q_q;

      if (sin_s)                                  brk_cnt_d = frame_ticks;
      else if (baudout_i && brk_cnt_q != '0)      brk_cnt_d = brk_cnt_q - CNT_W'(1);

      if (baudout_i && state_q != IDLE) tick_cnt_d = bit_end ? '0 : tick_cnt_q + CNT_W'(1);

      if (pend_q && sin_s) begin
         pend_d = 1'b0;
         push_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (fall && !break_q) begin
               state_d    = START;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               data_d     = '0;
               pe_d       = 1'b0;
               all_low_d  = 1'b1;
            end
         end
         START: begin
            if (sample_tick && maj) state_d = IDLE;
            else if (bit_end)       state_d = DATA;
         end
         DATA: begin
            if (sample_tick) data_d[bit_cnt_q[2:0]] = maj;
            if (bit_end) begin
               if (bit_cnt_q == last_bit) state_d = csr_i.lcr.pen ? PARITY : STOP;
               else                       bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         PARITY: begin
            if (sample_tick) pe_d = maj ^ exp_par;
            if (bit_end)     state_d = STOP;
         end
         STOP: begin
            if (sample_tick) begin
               state_d = IDLE;
               q_d     = '{d: data_q, pe: pe_q, fe: ~maj, bi: 1'b0};
               if (!maj && all_low_q && !sin_s) pend_d = 1'b1;
               else                             push_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (brk_hit) begin
         state_d = IDLE;
         break_d = 1'b1;
         pend_d  = 1'b0;
         push_d  = 1'b1;
         q_d     = '{d: 8'h00, pe: 1'b0, fe: 1'b1, bi: 1'b1};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         brk_cnt_q  <= frame_ticks;
         data_q     <= '0;
         pe_q       <= 1'b0;
         all_low_q  <= 1'b0;
         pend_q     <= 1'b0;
         break_q    <= 1'b0;
         push_q     <= 1'b0;
         q_q        <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         brk_cnt_q  <= brk_cnt_d;
         data_q     <= data_d;
         pe_q       <= pe_d;
         all_low_q  <= all_low_d;
         pend_q     <= pend_d;
         break_q    <= break_d;
         push_q     <= push_d;
         q_q        <= q_d;
      end
   end

   assign push_o  = push_q;
   assign q_o     = q_q;
   assign break_o = break_q;

`ifdef UART16550_RXP_TIMEOUT_EN
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d, to_reload;
   logic             timeout_q, timeout_d;

   assign to_reload = CNT_W'(TIMEOUT_CHARS * rxp_frame_ticks(csr_i.lcr, OVERSAMPLE));

   always_comb begin
      to_cnt_d = to_cnt_q;
      if (push_q || fifo_rd_i || fifo_empty_i || state_q != IDLE) to_cnt_d = to_reload;
      else if (baudout_i && to_cnt_q != '0)                        to_cnt_d = to_cnt_q - CNT_W'(1);
      timeout_d = (to_cnt_d == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         to_cnt_q  <= to_reload;
         timeout_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   logic unused_fifo;
   assign unused_fifo = fifo_empty_i ^ fifo_rd_i;
   assign timeout_o   = 1'b0;
`endif

endmodule
